mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/cpu_pkg.sv | 26 ++
 rtl/arb_starve_ctr.sv | 34 +++
 rtl/mem_port_arbiter.sv | 165 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the memory port arbiter: FSM states, owner
// encoding, default widths and counter widths.
package cpu_pkg;

    localparam int DEF_ADDR_W     = 32;
    localparam int DEF_DATA_W     = 32;
    localparam int DEF_MEM_LAT    = 2;
    localparam int DEF_STARVE_MAX = 4;

    // Both counters cover the 1-15 parameter range.
    localparam int LAT_CNT_W    = 4;
    localparam int STARVE_CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_e;

    typedef enum logic {
        OWN_FETCH = 1'b0,
        OWN_DATA  = 1'b1
    } arb_owner_e;

endpackage

// File: rtl/arb_starve_ctr.sv
// Fetch starvation counter for mem_port_arbiter. Present only when
// ARB_STARVE_GUARD_EN is defined; counts data grants that overtake a
// waiting fetch and flags when the fetch must win the next grant.
`ifdef ARB_STARVE_GUARD_EN
module arb_starve_ctr
    import cpu_pkg::*;
#(
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic clk,
    input  logic rst,
    input  logic i_if_req,
    input  logic i_data_grant,
    input  logic i_fetch_grant,
    output logic o_starve
);

    logic [STARVE_CNT_W-1:0] r_cnt;

    // Count data grants while fetch waits; any fetch grant or idle fetch side restarts the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_fetch_grant || !i_if_req) begin
            r_cnt <= '0;
        end else if (i_data_grant && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_starve = (r_cnt >= STARVE_CNT_W'(STARVE_MAX));

endmodule
`endif

// File: rtl/mem_port_arbiter.sv
// Single-ported memory arbiter between instruction fetch and data access.
// IDLE -> ISSUE (one-cycle mem_req) -> WAIT (MEM_LAT cycles) -> RESP (ack).
// Data wins simultaneous requests. Optional fetch starvation guard is
// enabled by defining ARB_STARVE_GUARD_EN.
module mem_port_arbiter
    import cpu_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int MEM_LAT    = DEF_MEM_LAT,
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ADDR_W-1:0]     if_addr,
    input  logic                  if_flush,
    output logic                  if_ack,
    output logic [DATA_W-1:0]     if_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    input  logic [DATA_W/8-1:0]   d_be,
    output logic                  d_ack,
    output logic [DATA_W-1:0]     d_rdata,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_be,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  arb_busy
);

    arb_state_e             r_state;
    arb_state_e             w_next;
    arb_owner_e             r_owner;
    logic [LAT_CNT_W-1:0]   r_lat_cnt;
    logic                   r_flushed;
    logic                   r_we;
    logic [ADDR_W-1:0]      r_addr;
    logic [DATA_W-1:0]      r_wdata;
    logic [DATA_W/8-1:0]    r_be;
    logic [DATA_W-1:0]      r_cap;
    logic [DATA_W-1:0]      r_if_rdata;
    logic [DATA_W-1:0]      r_d_rdata;

    logic                   w_starve;
    logic                   w_pick_fetch;
    logic                   w_idle_grant;
    logic                   w_fetch_grant;
    logic                   w_data_grant;
    logic                   w_rdata_ready;

    assign w_idle_grant  = (r_state == ST_IDLE) && (if_req || d_req);
    assign w_pick_fetch  = if_req && (!d_req || w_starve);
    assign w_fetch_grant = w_idle_grant && w_pick_fetch;
    assign w_data_grant  = w_idle_grant && !w_pick_fetch;
    assign w_rdata_ready = (r_state == ST_WAIT) && (r_lat_cnt == '0);
    assign arb_busy      = (r_state != ST_IDLE);

`ifdef ARB_STARVE_GUARD_EN
    arb_starve_ctr #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve (
        .clk           (clk),
        .rst           (rst),
        .i_if_req      (if_req),
        .i_data_grant  (w_data_grant),
        .i_fetch_grant (w_fetch_grant),
        .o_starve      (w_starve)
    );
`else
    // Strict data priority: STARVE_MAX is never zero, so fetch never overrides.
    assign w_starve = (STARVE_MAX == 0);
`endif

    // Next-state and command/ack decode; mem command fields are zero outside ISSUE.
    always_comb begin
        w_next    = r_state;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = '0;
        if_ack    = 1'b0;
        d_ack     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (if_req || d_req) w_next = ST_ISSUE;
            end
            ST_ISSUE: begin
                w_next    = ST_WAIT;
                mem_req   = 1'b1;
                mem_we    = r_we;
                mem_addr  = r_addr;
                mem_wdata = r_wdata;
                mem_be    = r_be;
            end
            ST_WAIT: begin
                if (r_lat_cnt == '0) w_next = ST_RESP;
            end
            ST_RESP: begin
                w_next = ST_IDLE;
                if (r_owner == OWN_FETCH) begin
                    if_ack = !r_flushed && !if_flush;
                end else begin
                    d_ack = 1'b1;
                end
            end
            default: w_next = ST_IDLE;
        endcase
        // Read data is presented alongside the ack, otherwise the last delivered value holds.
        if_rdata = if_ack ? r_cap : r_if_rdata;
        d_rdata  = (d_ack && !r_we) ? r_cap : r_d_rdata;
    end

    // Control state: FSM, owner, latency counter, flush marker and delivered read data.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_owner    <= OWN_FETCH;
            r_lat_cnt  <= '0;
            r_flushed  <= 1'b0;
            r_if_rdata <= '0;
            r_d_rdata  <= '0;
        end else begin
            r_state <= w_next;
            if (w_idle_grant) begin
                r_owner   <= w_pick_fetch ? OWN_FETCH : OWN_DATA;
                r_flushed <= 1'b0;
            end else if (if_flush && (r_owner == OWN_FETCH) &&
                         ((r_state == ST_ISSUE) || (r_state == ST_WAIT))) begin
                r_flushed <= 1'b1;
            end
            if (r_state == ST_ISSUE) begin
                r_lat_cnt <= LAT_CNT_W'(MEM_LAT - 1);
            end else if ((r_state == ST_WAIT) && (r_lat_cnt != '0)) begin
                r_lat_cnt <= r_lat_cnt - 1'b1;
            end
            if (if_ack) r_if_rdata <= r_cap;
            if (d_ack && !r_we) r_d_rdata <= r_cap;
        end
    end

    // Datapath: latch the winner's command at grant and capture memory data when it lands.
    always_ff @(posedge clk) begin
        if (w_idle_grant) begin
            if (w_pick_fetch) begin
                r_addr  <= if_addr;
                r_we    <= 1'b0;
                r_wdata <= '0;
                r_be    <= '1;
            end else begin
                r_addr  <= d_addr;
                r_we    <= d_we;
                r_wdata <= d_wdata;
                r_be    <= d_be;
            end
        end
        if (w_rdata_ready) r_cap <= mem_rdata;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: memory model with MEM_LAT read
// latency, scoreboard of expected acks, one task per scenario.
// Starvation expectations follow ARB_STARVE_GUARD_EN.
module tb_mem_port_arbiter;

    localparam int          ADDR_W     = 32;
    localparam int          DATA_W     = 32;
    localparam int          MEM_LAT    = 2;
    localparam int          STARVE_MAX = 4;
    localparam logic [31:0] JUNK       = 32'hBADB_AD00;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_flush, if_ack;
    logic [31:0] if_addr, if_rdata;
    logic        d_req, d_we, d_ack;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [3:0]  d_be;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        arb_busy;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .MEM_LAT    (MEM_LAT),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_flush  (if_flush),
        .if_ack    (if_ack),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_be      (d_be),
        .d_ack     (d_ack),
        .d_rdata   (d_rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_rdata (mem_rdata),
        .arb_busy  (arb_busy)
    );

    typedef struct {
        bit          fetch;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] mem [logic [31:0]];
    logic [31:0] exp_if_hold = '0;
    logic [31:0] exp_d_hold  = '0;
    int          rd_cnt = 0;
    bit          rd_act = 1'b0;
    logic [31:0] rd_data = '0;

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic push_exp(input bit fetch, input logic [31:0] data);
        exp_t e;
        e.fetch = fetch;
        e.data  = data;
        sb.push_back(e);
        if (fetch) exp_if_hold = data;
        else       exp_d_hold  = data;
    endtask

    task automatic wait_ack(input bit fetch, output int cyc);
        cyc = -1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (fetch ? if_ack : d_ack) begin
                cyc = c;
                break;
            end
        end
    endtask

    // Memory model: read data is valid only in the cycle MEM_LAT after mem_req.
    always @(negedge clk) begin
        if (rd_act) begin
            rd_cnt--;
            if (rd_cnt < 0) rd_act = 1'b0;
        end
        if (mem_req) begin
            if (mem_we) mem[mem_addr] = mem_wdata;
            rd_data = mem_val(mem_addr);
            rd_cnt  = MEM_LAT;
            rd_act  = 1'b1;
        end
        mem_rdata = (rd_act && rd_cnt == 0) ? rd_data : JUNK;
    end

    // Scoreboard: every ack pops the oldest expectation.
    always @(negedge clk) begin : mon
        exp_t        e;
        logic [31:0] got;
        if (!rst && (if_ack || d_ack)) begin
            checks++;
            if ((if_ack && d_ack) || mem_req) begin
                errors++;
                $display("FAIL strobe_excl: if_ack=%0b d_ack=%0b mem_req=%0b want one strobe", if_ack, d_ack, mem_req);
            end
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got if_ack=%0b d_ack=%0b want no ack", if_ack, d_ack);
            end else begin
                e = sb.pop_front();
                if (e.fetch !== if_ack) begin
                    errors++;
                    $display("FAIL sb_owner: got fetch=%0b want fetch=%0b", if_ack, e.fetch);
                end else begin
                    got = e.fetch ? if_rdata : d_rdata;
                    checks++;
                    if (got !== e.data) begin
                        errors++;
                        $display("FAIL sb_rdata: got %h want %h (fetch=%0b)", got, e.data, e.fetch);
                    end
                end
            end
        end
    end

    task automatic test_reset;
        logic [136:0] vec;
        rst = 1'b1; if_req = 0; if_flush = 0; if_addr = '0;
        d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; d_be = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vec = {mem_req, mem_we, mem_addr, mem_wdata, mem_be, if_ack, if_rdata, d_ack, d_rdata, arb_busy};
        checks++;
        if (vec !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h want 0", vec);
        end
        @(posedge clk); #1 rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (arb_busy !== 1'b0 || mem_req !== 1'b0) begin
                errors++;
                $display("FAIL idle_hold: got busy=%0b mem_req=%0b want 0 0", arb_busy, mem_req);
            end
        end
    endtask

    task automatic test_single_fetch;
        int lat;
        lat = -1;
        mem[32'h4] = 32'h0050_0093;
        @(posedge clk); #1;
        push_exp(1'b1, 32'h0050_0093);
        if_req = 1'b1; if_addr = 32'h4;
        for (int c = 0; c <= MEM_LAT + 2; c++) begin
            @(negedge clk);
            checks++;
            if (mem_req !== (c == 1)) begin
                errors++;
                $display("FAIL fetch_mem_req c%0d: got %0b want %0b", c, mem_req, (c == 1));
            end
            if (c == 1) begin
                checks++;
                if ({mem_addr, mem_we, mem_be, arb_busy} !== {32'h4, 1'b0, 4'hF, 1'b1}) begin
                    errors++;
                    $display("FAIL fetch_cmd: got addr=%h we=%0b be=%h busy=%0b want 4 0 f 1", mem_addr, mem_we, mem_be, arb_busy);
                end
            end
            if (if_ack && lat < 0) lat = c;
        end
        checks++;
        if (lat != MEM_LAT + 2) begin
            errors++;
            $display("FAIL fetch_latency: got %0d want %0d", lat, MEM_LAT + 2);
        end
        @(posedge clk); #1 if_req = 1'b0;
    endtask

    task automatic test_priority;
        int cd, gap, cf;
        mem[32'h100] = 32'h1234_5678;
        @(posedge clk); #1;
        push_exp(1'b0, 32'h1234_5678);
        push_exp(1'b1, mem_val(32'h8));
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100; d_be = 4'hF;
        if_req = 1'b1; if_addr = 32'h8;
        wait_ack(1'b0, cd);
        checks++;
        if (cd != MEM_LAT + 2) begin
            errors++;
            $display("FAIL prio_data_first: got d_ack at %0d want %0d", cd, MEM_LAT + 2);
        end
        @(posedge clk); #1 d_req = 1'b0;
        gap = -1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (mem_req) begin
                gap = k;
                checks++;
                if (mem_addr !== 32'h8) begin
                    errors++;
                    $display("FAIL prio_fetch_addr: got %h want 00000008", mem_addr);
                end
                break;
            end
        end
        checks++;
        if (gap != 2) begin
            errors++;
            $display("FAIL prio_fetch_issue: got %0d cycles after d_ack want 2", gap);
        end
        wait_ack(1'b1, cf);
        checks++;
        if (cf != MEM_LAT) begin
            errors++;
            $display("FAIL prio_fetch_ack: got %0d want %0d", cf, MEM_LAT);
        end
        @(posedge clk); #1 if_req = 1'b0;
    endtask

    task automatic test_store;
        int  c;
        bit  found;
        @(posedge clk); #1;
        push_exp(1'b0, exp_d_hold);
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'hDEAD_BEEF; d_be = 4'hF;
        found = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (mem_req) begin
                found = 1'b1;
                checks++;
                if ({mem_we, mem_addr, mem_wdata, mem_be} !== {1'b1, 32'h200, 32'hDEAD_BEEF, 4'hF}) begin
                    errors++;
                    $display("FAIL store_cmd: got we=%0b addr=%h wdata=%h be=%h want 1 200 deadbeef f", mem_we, mem_addr, mem_wdata, mem_be);
                end
                break;
            end
        end
        checks++;
        if (!found) begin errors++; $display("FAIL store_issue: got no mem_req want one"); end
        wait_ack(1'b0, c);
        checks++;
        if (c != MEM_LAT) begin errors++; $display("FAIL store_ack: got %0d want %0d", c, MEM_LAT); end
        @(posedge clk); #1;
        d_we = 1'b0;
        push_exp(1'b0, mem_val(32'h200));
        d_be = 4'h3;
        found = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (mem_req) begin
                found = 1'b1;
                checks++;
                if ({mem_we, mem_be} !== {1'b0, 4'h3}) begin
                    errors++;
                    $display("FAIL load_cmd: got we=%0b be=%h want 0 3", mem_we, mem_be);
                end
                break;
            end
        end
        checks++;
        if (!found) begin errors++; $display("FAIL load_issue: got no mem_req want one"); end
        wait_ack(1'b0, c);
        checks++;
        if (c < 0) begin errors++; $display("FAIL load_ack: got timeout want ack"); end
        @(posedge clk); #1 d_req = 1'b0; d_be = 4'hF;
    endtask

    task automatic test_starve;
        int nd, fetch_at;
`ifndef ARB_STARVE_GUARD_EN
        int c;
`endif
        @(posedge clk); #1;
`ifdef ARB_STARVE_GUARD_EN
        for (int i = 0; i < STARVE_MAX; i++) push_exp(1'b0, mem_val(32'h300));
        push_exp(1'b1, mem_val(32'h10));
`else
        for (int i = 0; i < 6; i++) push_exp(1'b0, mem_val(32'h300));
`endif
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300; d_be = 4'hF;
        if_req = 1'b1; if_addr = 32'h10;
        nd = 0; fetch_at = -1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (if_ack) begin fetch_at = nd; break; end
            if (d_ack) nd++;
`ifndef ARB_STARVE_GUARD_EN
            if (nd == 6) break;
`endif
        end
        @(posedge clk); #1 d_req = 1'b0;
`ifdef ARB_STARVE_GUARD_EN
        if_req = 1'b0;
        checks++;
        if (fetch_at != STARVE_MAX) begin
            errors++;
            $display("FAIL starve_guard: got fetch after %0d data grants want %0d", fetch_at, STARVE_MAX);
        end
`else
        checks++;
        if (fetch_at != -1 || nd != 6) begin
            errors++;
            $display("FAIL starve_strict: got fetch_at=%0d data=%0d want -1 6", fetch_at, nd);
        end
        push_exp(1'b1, mem_val(32'h10));
        wait_ack(1'b1, c);
        checks++;
        if (c != MEM_LAT + 2) begin
            errors++;
            $display("FAIL starve_release: got %0d want %0d", c, MEM_LAT + 2);
        end
        @(posedge clk); #1 if_req = 1'b0;
`endif
    endtask

    task automatic test_flush;
        logic [31:0] hold;
        int          c;
        hold = exp_if_hold;
        @(posedge clk); #1 if_req = 1'b1; if_addr = 32'h20;
        @(posedge clk); #1;
        @(posedge clk); #1 if_flush = 1'b1; if_req = 1'b0;
        @(posedge clk); #1 if_flush = 1'b0;
        for (int k = 3; k <= 6; k++) begin
            @(negedge clk);
            checks++;
            if (if_ack !== 1'b0) begin errors++; $display("FAIL flush_no_ack c%0d: got %0b want 0", k, if_ack); end
            if (k == 4) begin
                checks++;
                if ({arb_busy, if_rdata} !== {1'b1, hold}) begin
                    errors++;
                    $display("FAIL flush_resp: got busy=%0b rdata=%h want 1 %h", arb_busy, if_rdata, hold);
                end
            end
            if (k == 5) begin
                checks++;
                if (arb_busy !== 1'b0) begin errors++; $display("FAIL flush_idle: got busy=%0b want 0", arb_busy); end
            end
        end
        @(posedge clk); #1;
        push_exp(1'b1, mem_val(32'h24));
        if_req = 1'b1; if_addr = 32'h24; if_flush = 1'b1;
        @(negedge clk);
        @(posedge clk); #1 if_flush = 1'b0;
        wait_ack(1'b1, c);
        checks++;
        if (c != MEM_LAT + 1) begin errors++; $display("FAIL flush_idle_ignored: got %0d want %0d", c, MEM_LAT + 1); end
        @(posedge clk); #1 if_req = 1'b0;
        push_exp(1'b0, mem_val(32'h100));
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100; if_flush = 1'b1;
        wait_ack(1'b0, c);
        checks++;
        if (c != MEM_LAT + 2) begin errors++; $display("FAIL flush_data_ignored: got %0d want %0d", c, MEM_LAT + 2); end
        @(posedge clk); #1 d_req = 1'b0; if_flush = 1'b0;
    endtask

    task automatic test_reset_mid;
        logic [136:0] vec;
        int           c;
        @(posedge clk); #1 if_req = 1'b1; if_addr = 32'h30;
        @(posedge clk); #1;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0; if_req = 1'b0;
        exp_if_hold = '0; exp_d_hold = '0;
        @(negedge clk);
        vec = {mem_req, mem_we, mem_addr, mem_wdata, mem_be, if_ack, if_rdata, d_ack, d_rdata, arb_busy};
        checks++;
        if (vec !== '0) begin errors++; $display("FAIL midreset_outputs: got %h want 0", vec); end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checks++;
            if ({if_ack, d_ack, arb_busy} !== 3'b000) begin
                errors++;
                $display("FAIL midreset_quiet: got if_ack=%0b d_ack=%0b busy=%0b want 0 0 0", if_ack, d_ack, arb_busy);
            end
        end
        @(posedge clk); #1;
        push_exp(1'b1, mem_val(32'h34));
        if_req = 1'b1; if_addr = 32'h34;
        wait_ack(1'b1, c);
        checks++;
        if (c != MEM_LAT + 2) begin errors++; $display("FAIL midreset_recover: got %0d want %0d", c, MEM_LAT + 2); end
        @(posedge clk); #1 if_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_fetch();
        test_priority();
        test_store();
        test_starve();
        test_flush();
        test_reset_mid();
        repeat (4) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: got %0d pending want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
